serial_adder_ctrl: RTL

- Bit-serial adder controller that sequences a single one_bit_full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the result register.
- Presents a start/busy/done handshake to the surrounding lab datapath.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/one_bit_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Counter width, kept at least one bit so WIDTH = 1 still elaborates.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module one_bit_full_adder (
    input  logic i0,
    input  logic i1,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = i0 ^ i1 ^ cin;
    assign cout = (i0 & i1) | (cin & (i0 ^ i1));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one full-adder cell over WIDTH cycles
// behind a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    one_bit_full_adder u_fa (
        .i0   (sh_a[0]),
        .i1   (sh_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New bit enters at the MSB so the LSB-first stream lands in place.
    if (WIDTH == 1) begin : g_acc1
        assign acc_nxt = fa_sum;
    end else begin : g_accn
        assign acc_nxt = {fa_sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum  <= acc_nxt;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
